rv32_core: RTL and testbench



---
 rtl/rv32_pkg.sv | 67 ++++++
 rtl/rv32_alu.sv | 30 +++
 rtl/rv32_core.sv | 191 +++++++++++++++++++
 tb/tb_rv32_core.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared constants and types for the rv32_core slice.
// Holds RV32I opcode and funct3/funct7 encodings, the ALU operation enum and
// the funct3 -> ALU operation decode used by the register and immediate forms.
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load/store funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // ALU funct3 (F3_SR covers SRL/SRA, F3_ADD covers ADD/SUB)
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_t;

  // alt selects SUB/SRA; the caller decides when alt is meaningful.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      F3_ADD:  op = alt ? AluSub : AluAdd;
      F3_SLL:  op = AluSll;
      F3_SLT:  op = AluSlt;
      F3_SLTU: op = AluSltu;
      F3_XOR:  op = AluXor;
      F3_SR:   op = alt ? AluSra : AluSrl;
      F3_OR:   op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// rv32_alu: purely combinational 32-bit integer ALU.
// Ports: a_i, b_i - operands; op_i - operation; result_o - 32-bit result.
// Shifts use the low 5 bits of b_i; SLT is signed, SLTU unsigned.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     op_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluSll:  result_o = a_i << b_i[4:0];
      AluSlt:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      AluSltu: result_o = {31'b0, a_i < b_i};
      AluXor:  result_o = a_i ^ b_i;
      AluSrl:  result_o = a_i >> b_i[4:0];
      AluSra:  result_o = $signed(a_i) >>> b_i[4:0];
      AluOr:   result_o = a_i | b_i;
      AluAnd:  result_o = a_i & b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32_core.sv
// rv32_core: single-cycle RV32I integer core with internal instruction and
// data memories. One instruction retires per rising clock edge.
// Ports: clk - clock; rst - synchronous active-high reset (pc <= RESET_PC,
// register file cleared, data memory untouched).
// Unsupported or malformed encodings execute as NOP (pc+4, no state change).
module rv32_core
  import rv32_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter string       IMEM_INIT  = "program.hex",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  logic [31:0] pc;
  logic [31:0] regs [0:31];
  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [31:0] dmem [0:DMEM_WORDS-1];

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr  = imem[pc[IAW+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [31:0] alu_b, alu_res;
  alu_op_t     alu_op;

  rv32_alu u_alu (
    .a_i      (rs1_val),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_res)
  );

  // Loads and stores both address through the ALU sum.
  logic [DAW-1:0] dmem_idx;
  logic [31:0]    ld_word, ld_data;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic           ld_ok;

  assign dmem_idx = alu_res[DAW+1:2];
  assign ld_word  = dmem[dmem_idx];
  assign ld_byte  = ld_word[{alu_res[1:0], 3'b000} +: 8];
  assign ld_half  = alu_res[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_ok   = 1'b1;
    ld_data = ld_word;
    case (funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LW:   ld_data = ld_word;
      F3_LBU:  ld_data = {24'b0, ld_byte};
      F3_LHU:  ld_data = {16'b0, ld_half};
      default: ld_ok   = 1'b0;
    endcase
  end

  logic br_taken;

  always_comb begin
    case (funct3)
      F3_BEQ:  br_taken = rs1_val == rs2_val;
      F3_BNE:  br_taken = rs1_val != rs2_val;
      F3_BLT:  br_taken = $signed(rs1_val) < $signed(rs2_val);
      F3_BGE:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
      F3_BLTU: br_taken = rs1_val < rs2_val;
      F3_BGEU: br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  logic [31:0] pc_plus4, pc_next, rd_wdata, st_data;
  logic [3:0]  st_mask;
  logic        rd_we;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    alu_b    = imm_i;
    alu_op   = AluAdd;
    rd_we    = 1'b0;
    rd_wdata = alu_res;
    pc_next  = pc_plus4;
    st_mask  = 4'b0000;
    st_data  = rs2_val;
    case (opcode)
      OP_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OP_AUIPC: begin
        rd_we    = 1'b1;
        rd_wdata = pc + imm_u;
      end
      OP_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we    = 1'b1;
          rd_wdata = pc_plus4;
          pc_next  = alu_res & ~32'd1;
        end
      end
      OP_BRANCH: begin
        if (br_taken) pc_next = pc + imm_b;
      end
      OP_LOAD: begin
        rd_we    = ld_ok;
        rd_wdata = ld_data;
      end
      OP_STORE: begin
        alu_b = imm_s;
        case (funct3)
          F3_SB: begin
            st_mask = 4'b0001 << alu_res[1:0];
            st_data = {4{rs2_val[7:0]}};
          end
          F3_SH: begin
            st_mask = alu_res[1] ? 4'b1100 : 4'b0011;
            st_data = {2{rs2_val[15:0]}};
          end
          F3_SW:   st_mask = 4'b1111;
          default: st_mask = 4'b0000;
        endcase
      end
      OP_IMM: begin
        alu_op = alu_decode(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
        // Shift-immediates carry funct7 in imm[11:5]; other values are illegal.
        if (funct3 == F3_SLL)     rd_we = (funct7 == F7_BASE);
        else if (funct3 == F3_SR) rd_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                      rd_we = 1'b1;
      end
      OP_REG: begin
        alu_b  = rs2_val;
        alu_op = alu_decode(funct3, funct7 == F7_ALT);
        rd_we  = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (rd_we && (rd != 5'd0)) regs[rd] <= rd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (st_mask[lane]) dmem[dmem_idx][8*lane +: 8] <= st_data[8*lane +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rv32_core.sv
module tb_rv32_core;

  localparam int IMEM_WORDS = 256;
  localparam int DMEM_WORDS = 256;
  localparam int END_IDX    = 240;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  logic [31:0] prog   [0:IMEM_WORDS-1];
  logic [31:0] m_pc;
  logic [31:0] m_regs [0:31];
  logic [31:0] m_dmem [0:DMEM_WORDS-1];

  rv32_core #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS),
    .IMEM_INIT  (""),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] m, s;
    m = (32'd1 << bits) - 32'd1;
    s = 32'd1 << (bits - 1);
    return ((v & m) ^ s) - s;
  endfunction

  function automatic logic [31:0] alu_model(input int f3, input bit alt,
                                            input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (f3)
      0: return alt ? a - b : a + b;
      1: return a << sh;
      2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a ^ b;
      5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Executes prog at m_pc on the model state; wrd = register written (0 if none).
  task automatic iss_step(output int wrd);
    logic [31:0] ins, a, b, r, addr, w, nxt, mask, immi;
    int op, rd, f3, f7, sh;
    bit take;
    ins  = prog[(m_pc >> 2) % IMEM_WORDS];
    op   = int'(ins & 32'h7F);
    rd   = int'((ins >> 7) & 31);
    f3   = int'((ins >> 12) & 7);
    f7   = int'(ins >> 25);
    a    = m_regs[(ins >> 15) & 31];
    b    = m_regs[(ins >> 20) & 31];
    immi = sx(ins >> 20, 12);
    nxt  = m_pc + 4;
    wrd  = 0;
    r    = 0;
    case (op)
      'h37: begin r = ins & 32'hFFFFF000; wrd = rd; end
      'h17: begin r = m_pc + (ins & 32'hFFFFF000); wrd = rd; end
      'h6F: begin
        r   = m_pc + 4;
        wrd = rd;
        nxt = m_pc + sx((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
                        (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
      end
      'h67: if (f3 == 0) begin r = m_pc + 4; wrd = rd; nxt = (a + immi) & ~32'd1; end
      'h63: begin
        case (f3)
          0: take = (a == b);
          1: take = (a != b);
          4: take = ($signed(a) < $signed(b));
          5: take = ($signed(a) >= $signed(b));
          6: take = (a < b);
          7: take = (a >= b);
          default: take = 0;
        endcase
        if (take)
          nxt = m_pc + sx((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                          (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
      end
      'h03: begin
        addr = a + immi;
        w    = m_dmem[(addr >> 2) % DMEM_WORDS];
        wrd  = rd;
        case (f3)
          0: r = sx(w >> (8 * (addr % 4)), 8);
          1: r = sx(w >> (16 * ((addr >> 1) % 2)), 16);
          2: r = w;
          4: r = (w >> (8 * (addr % 4))) & 32'hFF;
          5: r = (w >> (16 * ((addr >> 1) % 2))) & 32'hFFFF;
          default: wrd = 0;
        endcase
      end
      'h23: begin
        addr = a + sx(((ins >> 25) << 5) | ((ins >> 7) & 31), 12);
        mask = 0;
        sh   = 0;
        case (f3)
          0: begin mask = 32'hFF;   sh = 8 * int'(addr % 4); end
          1: begin mask = 32'hFFFF; sh = 16 * int'((addr >> 1) % 2); end
          2: mask = 32'hFFFFFFFF;
          default: mask = 0;
        endcase
        w = m_dmem[(addr >> 2) % DMEM_WORDS];
        m_dmem[(addr >> 2) % DMEM_WORDS] = (w & ~(mask << sh)) | ((b & mask) << sh);
      end
      'h13: begin
        if ((f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 32)) || (f3 != 1 && f3 != 5))
          begin r = alu_model(f3, f3 == 5 && f7 == 32, a, immi); wrd = rd; end
      end
      'h33: begin
        if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)))
          begin r = alu_model(f3, f7 == 32, a, b); wrd = rd; end
      end
      default: ;
    endcase
    if (wrd != 0) m_regs[wrd] = r;
    m_pc = nxt;
  endtask

  // ---------------- helpers ----------------
  task automatic put(input int idx, input logic [31:0] w);
    prog[idx] = w;
    dut.imem[idx] = w;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < IMEM_WORDS; i++) put(i, NOP);
  endtask

  // Callers are always parked on a falling edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int edges);
    rst = 1'b1;
    run(edges);
    rst = 1'b0;
  endtask

  task automatic random_test(input int round);
    int wrd, off, tgt, rd, rs1, rs2, f3, imm, k;
    string tg;
    clear_prog();
    for (int r = 1; r < 32; r++) begin
      put(2 * r - 2, enc_u(int'($urandom()), r, 7'h37));
      put(2 * r - 1, enc_i(int'($urandom_range(0, 4095)), r, 0, r, 7'h13));
    end
    for (int w = 0; w < 16; w++) put(62 + w, enc_s(4 * w, w + 1, 0, 2));
    for (int i = 78; i < END_IDX; i++) begin
      k   = int'($urandom_range(0, 9));
      rd  = int'($urandom_range(0, 31));
      rs1 = int'($urandom_range(0, 31));
      rs2 = int'($urandom_range(0, 31));
      f3  = int'($urandom_range(0, 7));
      off = 4 * int'($urandom_range(1, 8));
      if (i + off / 4 > END_IDX) off = 4 * (END_IDX - i);
      case (k)
        0, 1, 2: put(i, enc_r(($urandom_range(0, 3) == 0) ? 32 : 0, rs2, rs1, f3, rd));
        3, 4: begin
          imm = int'($urandom_range(0, 4095));
          if (f3 == 1 || f3 == 5) imm = (imm & 31) | (($urandom_range(0, 1) == 1) ? 'h400 : 0);
          put(i, enc_i(imm, rs1, f3, rd, 7'h13));
        end
        5: put(i, enc_u(int'($urandom()), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17));
        6: put(i, enc_i(int'($urandom_range(0, 63)), 0, f3, rd, 7'h03));
        7: put(i, enc_s(int'($urandom_range(0, 63)), rs2, 0, int'($urandom_range(0, 3))));
        8: put(i, enc_b(off, rs2, rs1, f3));
        default: begin
          tgt = i + off / 4;
          case ($urandom_range(0, 5))
            0, 1: put(i, enc_j(off, rd));
            2, 3: put(i, enc_i(4 * tgt + int'($urandom_range(0, 1)), 0, 0, rd, 7'h67));
            4: put(i, ($urandom_range(0, 1) == 1) ? 32'h0FF0_000F : 32'h0000_0073);
            default: put(i, ($urandom_range(0, 1) == 1) ? 32'h3402_9073 : 32'h0000_000B);
          endcase
        end
      endcase
    end
    put(END_IDX, enc_j(0, 0));

    do_reset(1);
    m_pc = 0;
    for (int r = 0; r < 32; r++) m_regs[r] = 0;
    for (int c = 0; c < 260; c++) begin
      iss_step(wrd);
      run(1);
      tg = $sformatf("rnd%0d_pc_c%0d", round, c);
      check_eq(tg, dut.pc, m_pc);
      if (wrd != 0) begin
        tg = $sformatf("rnd%0d_x%0d_c%0d", round, wrd, c);
        check_eq(tg, dut.regs[wrd], m_regs[wrd]);
      end
    end
    for (int r = 0; r < 32; r++) begin
      tg = $sformatf("rnd%0d_final_x%0d", round, r);
      check_eq(tg, dut.regs[r], m_regs[r]);
    end
    for (int w = 0; w < 16; w++) begin
      tg = $sformatf("rnd%0d_dmem%0d", round, w);
      check_eq(tg, dut.dmem[w], m_dmem[w]);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    for (int w = 0; w < DMEM_WORDS; w++) m_dmem[w] = 0;
    @(negedge clk);

    // Reset
    clear_prog();
    do_reset(2);
    check_eq("reset_pc", dut.pc, 32'h0);
    for (int r = 0; r < 32; r++) check_eq($sformatf("reset_x%0d", r), dut.regs[r], 32'h0);
    run(1);
    check_eq("reset_pc_next", dut.pc, 32'h4);

    // ALU, x0, LUI/AUIPC
    clear_prog();
    put(0, enc_i(5, 0, 0, 1, 7'h13));
    put(1, enc_i(-3, 0, 0, 2, 7'h13));
    put(2, enc_r(0, 2, 1, 0, 3));
    put(3, enc_r(32, 2, 1, 0, 4));
    put(4, enc_r(0, 1, 2, 2, 5));
    put(5, enc_r(0, 1, 2, 3, 6));
    put(6, enc_i('h401, 2, 5, 7, 7'h13));
    put(7, enc_i(7, 0, 0, 0, 7'h13));
    put(8, enc_u(1, 9, 7'h17));
    put(9, enc_u('h12345, 8, 7'h37));
    do_reset(1);
    run(10);
    check_eq("add", dut.regs[3], 32'd2);
    check_eq("sub", dut.regs[4], 32'd8);
    check_eq("slt", dut.regs[5], 32'd1);
    check_eq("sltu", dut.regs[6], 32'd0);
    check_eq("srai", dut.regs[7], 32'hFFFF_FFFE);
    check_eq("x0", dut.regs[0], 32'h0);
    check_eq("lui", dut.regs[8], 32'h1234_5000);
    check_eq("auipc", dut.regs[9], 32'h0000_1020);

    // Memory
    clear_prog();
    put(0, enc_u('h80FF8, 1, 7'h37));
    put(1, enc_i('hF01, 1, 0, 1, 7'h13));
    put(2, enc_s(8, 1, 0, 2));
    put(3, enc_i(8, 0, 0, 2, 7'h03));
    put(4, enc_i(9, 0, 0, 3, 7'h03));
    put(5, enc_i(10, 0, 4, 4, 7'h03));
    put(6, enc_i(10, 0, 1, 5, 7'h03));
    put(7, enc_i('hAA, 0, 0, 6, 7'h13));
    put(8, enc_s(9, 6, 0, 0));
    put(9, enc_i(8, 0, 2, 7, 7'h03));
    do_reset(1);
    run(10);
    check_eq("sw_val", dut.regs[1], 32'h80FF_7F01);
    check_eq("lb8", dut.regs[2], 32'h0000_0001);
    check_eq("lb9", dut.regs[3], 32'h0000_007F);
    check_eq("lbu10", dut.regs[4], 32'h0000_00FF);
    check_eq("lh10", dut.regs[5], 32'hFFFF_80FF);
    check_eq("sb_lw", dut.regs[7], 32'h80FF_AA01);

    // Control flow
    clear_prog();
    put(0, enc_i(1, 0, 0, 1, 7'h13));
    put(1, enc_b(8, 1, 1, 0));
    put(2, enc_i(9, 0, 0, 2, 7'h13));
    put(3, enc_i(-1, 0, 0, 3, 7'h13));
    put(4, enc_i(1, 0, 0, 4, 7'h13));
    put(5, enc_b(8, 4, 3, 6));
    put(6, enc_i(7, 0, 0, 5, 7'h13));
    put(7, enc_j('h24, 0));
    put(16, enc_j('h10, 6));
    put(20, enc_i('h61, 0, 0, 7, 7'h13));
    put(21, enc_i(0, 7, 0, 8, 7'h67));
    put(24, enc_j(0, 0));
    do_reset(1);
    run(8);
    check_eq("jal_pc", dut.pc, 32'h50);
    check_eq("jal_rd", dut.regs[6], 32'h44);
    run(2);
    check_eq("jalr_pc", dut.pc, 32'h60);
    check_eq("jalr_rd", dut.regs[8], 32'h58);
    check_eq("beq_skip", dut.regs[2], 32'h0);
    check_eq("bltu_fall", dut.regs[5], 32'd7);

    // Mid-run reset
    clear_prog();
    put(0, enc_i('h55, 0, 0, 1, 7'h13));
    put(1, enc_s(16, 1, 0, 2));
    put(2, enc_i(3, 0, 0, 2, 7'h13));
    put(3, enc_i(4, 0, 0, 3, 7'h13));
    put(4, enc_i(5, 0, 0, 4, 7'h13));
    put(5, enc_s(16, 0, 0, 2));
    put(6, enc_i(6, 0, 0, 5, 7'h13));
    do_reset(1);
    run(5);
    check_eq("mid_pre_pc", dut.pc, 32'h14);
    check_eq("mid_pre_x4", dut.regs[4], 32'd5);
    do_reset(1);
    check_eq("mid_pc", dut.pc, 32'h0);
    for (int r = 1; r < 6; r++) check_eq($sformatf("mid_x%0d", r), dut.regs[r], 32'h0);
    check_eq("mid_dmem", dut.dmem[4], 32'h55);
    run(1);
    check_eq("mid_pc_next", dut.pc, 32'h4);

    // Randomized programs against the reference model
    for (int n = 0; n < 3; n++) random_test(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
